alu_rr_sequencer: RTL and testbench

Shares one 4-bit ALU instance (ports A, B, CTRL0, CTRL1 in; C, OVF out) between NUM_REQ requesters. Each requester submits an (op, a, b) transaction over a valid/ready handshake. A round-robin arbiter grants one transaction at a time, drives registered operands onto the ALU, captures the result one cycle later, and returns it on a per-requester response handshake. The block sits between the requester logic and the ALU in the user area.

---
 rtl/alu_rr_sequencer.sv | 136 +++++++++++++
 tb/tb_alu_rr_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_sequencer.sv
// alu_rr_sequencer: round-robin front end that time-shares one combinational 4-bit ALU among NUM_REQ requesters.
// Macros: ALU_RR_SEQUENCER_STATS_EN adds the stat_ops counter; USE_POWER_PINS adds vccd1/vssd1.
module alu_rr_sequencer #(
  parameter int NUM_REQ = 4,
  localparam int GW = $clog2(NUM_REQ)
) (
`ifdef USE_POWER_PINS
  inout  wire                  vccd1,
  inout  wire                  vssd1,
`endif
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [2*NUM_REQ-1:0] req_op,
  input  logic [4*NUM_REQ-1:0] req_a,
  input  logic [4*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   rsp_valid,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output logic [3:0]           rsp_c,
  output logic                 rsp_ovf,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic                 alu_ctrl0,
  output logic                 alu_ctrl1,
  input  logic [3:0]           alu_c,
  input  logic                 alu_ovf,
`ifdef ALU_RR_SEQUENCER_STATS_EN
  output logic                 busy,
  output logic [15:0]          stat_ops
`else
  output logic                 busy
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [NUM_REQ-1:0] FIRST_BIT = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t          state_r;
  logic [GW-1:0]   cur_r;
  logic [GW-1:0]   last_grant_r;
  logic [GW-1:0]   winner_s;
  logic            any_valid_s;
  logic            handshake_s;

  // Index reached after stepping 'step' places past 'base', wrapping at NUM_REQ.
  function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] base, input int step);
    int sum;
    sum = int'(base) + step;
    return GW'(sum % NUM_REQ);
  endfunction

  assign any_valid_s = |req_valid;
  assign handshake_s = |(req_valid & req_ready);

  // Round-robin winner: scan backwards so the nearest valid requester after last_grant overwrites the rest.
  always_comb begin
    winner_s = {GW{1'b0}};
    for (int k = NUM_REQ; k >= 1; k--) begin
      winner_s = req_valid[next_idx(last_grant_r, k)] ? next_idx(last_grant_r, k) : winner_s;
    end
  end

  // Offer acceptance only to the current winner while idle and out of reset.
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    if (rst_n && (state_r == IDLE) && any_valid_s) begin
      req_ready[winner_s] = 1'b1;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

  // Sequencer FSM: accept, let the ALU settle for one cycle, then hold the response until taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cur_r        <= {GW{1'b0}};
      last_grant_r <= GW'(NUM_REQ - 1);
      rsp_valid    <= {NUM_REQ{1'b0}};
      rsp_c        <= 4'h0;
      rsp_ovf      <= 1'b0;
      alu_a        <= 4'h0;
      alu_b        <= 4'h0;
      alu_ctrl0    <= 1'b0;
      alu_ctrl1    <= 1'b0;
      busy         <= 1'b0;
`ifdef ALU_RR_SEQUENCER_STATS_EN
      stat_ops     <= 16'h0000;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (handshake_s) begin
            alu_a     <= req_a[{winner_s, 2'b00} +: 4];
            alu_b     <= req_b[{winner_s, 2'b00} +: 4];
            alu_ctrl0 <= req_op[{winner_s, 1'b0}];
            alu_ctrl1 <= req_op[{winner_s, 1'b1}];
            cur_r     <= winner_s;
            busy      <= 1'b1;
            state_r   <= EXEC;
          end
        end
        EXEC: begin
          rsp_c     <= alu_c;
          rsp_ovf   <= alu_ovf;
          rsp_valid <= FIRST_BIT << cur_r;
          state_r   <= RESP;
        end
        RESP: begin
          // Only the owner's rsp_ready can release the response.
          if (rsp_ready[cur_r]) begin
            rsp_valid    <= {NUM_REQ{1'b0}};
            last_grant_r <= cur_r;
            busy         <= 1'b0;
            state_r      <= IDLE;
`ifdef ALU_RR_SEQUENCER_STATS_EN
            stat_ops     <= stat_ops + 16'h0001;
`endif
          end
        end
        default: begin
          rsp_valid <= {NUM_REQ{1'b0}};
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Self-checking bench for alu_rr_sequencer: directed scenarios plus randomized transactions
// checked against a transaction-level round-robin/ALU reference model.
module tb_alu_rr_sequencer;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2*N-1:0]  req_op;
  logic [4*N-1:0]  req_a, req_b;
  logic [3:0]      rsp_c, alu_a, alu_b, alu_c;
  logic            rsp_ovf, alu_ctrl0, alu_ctrl1, alu_ovf, busy;
`ifdef ALU_RR_SEQUENCER_STATS_EN
  logic [15:0]     stat_ops;
`endif
`ifdef USE_POWER_PINS
  wire vccd1 = 1'b1;
  wire vssd1 = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int last_grant;
  int ops_done;
  int dut_grant;
  logic [3:0] last_rsp_c;
  logic       last_rsp_ovf;
  logic [1:0] t_op [N];
  logic [3:0] t_a [N];
  logic [3:0] t_b [N];
  int order[$];
  longint hs_t[$];

  alu_rr_sequencer #(.NUM_REQ(N)) dut (
`ifdef USE_POWER_PINS
    .vccd1(vccd1), .vssd1(vssd1),
`endif
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_c(rsp_c), .rsp_ovf(rsp_ovf),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl0(alu_ctrl0), .alu_ctrl1(alu_ctrl1),
    .alu_c(alu_c), .alu_ovf(alu_ovf),
`ifdef ALU_RR_SEQUENCER_STATS_EN
    .stat_ops(stat_ops),
`endif
    .busy(busy)
  );

  // Behavioural 4-bit ALU: returns {ovf, c}.
  function automatic logic [4:0] alu_ref(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    case (op)
      2'd0: begin r = ia + ib; return {(r > 15), 4'(r)}; end
      2'd1: begin r = ia - ib; return {(ia < ib), 4'(r)}; end
      2'd2: return {1'b0, a & b};
      default: return {1'b0, (ia > ib) ? 4'd1 : 4'd0};
    endcase
  endfunction

  assign {alu_ovf, alu_c} = alu_ref({alu_ctrl1, alu_ctrl0}, alu_a, alu_b);

  function automatic int rr_pick(input int last, input logic [N-1:0] mask);
    for (int k = 1; k <= N; k++) begin
      if (mask[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic int first_set(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int i, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    t_op[i] = op; t_a[i] = a; t_b[i] = b;
    req_op[2*i +: 2] = op;
    req_a[4*i +: 4]  = a;
    req_b[4*i +: 4]  = b;
  endtask

  // One full transaction starting in IDLE; rsp_ready of the winner is held low for 'hold' extra RESP cycles.
  task automatic send(input logic [N-1:0] mask, input int hold);
    logic [4:0] exp;
    int w;
    w = rr_pick(last_grant, mask);
    req_valid = mask;
    rsp_ready = (hold > 0) ? ~(N'(1) << w) : {N{1'b1}};
    #1;
    check("idle_busy", busy, 0);
    check("idle_rsp_valid", rsp_valid, 0);
    check("req_ready_grant", req_ready, N'(1) << w);
    dut_grant = first_set(req_ready);
    order.push_back(dut_grant);
    hs_t.push_back($time);
    exp = alu_ref(t_op[w], t_a[w], t_b[w]);
    @(posedge clk); #1;
    check("exec_busy", busy, 1);
    check("exec_req_ready", req_ready, 0);
    check("exec_rsp_valid", rsp_valid, 0);
    check("alu_a", alu_a, t_a[w]);
    check("alu_b", alu_b, t_b[w]);
    check("alu_ctrl", {alu_ctrl1, alu_ctrl0}, t_op[w]);
    @(posedge clk); #1;
    check("rsp_valid", rsp_valid, N'(1) << w);
    check("rsp_c", rsp_c, exp[3:0]);
    check("rsp_ovf", rsp_ovf, exp[4]);
    check("resp_req_ready", req_ready, 0);
    last_rsp_c = rsp_c;
    last_rsp_ovf = rsp_ovf;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_rsp_valid", rsp_valid, N'(1) << w);
      check("hold_rsp_c", rsp_c, exp[3:0]);
      check("hold_req_ready", req_ready, 0);
      check("hold_busy", busy, 1);
      check("hold_alu_a", alu_a, t_a[w]);
    end
    rsp_ready = {N{1'b1}};
    @(posedge clk); #1;
    check("release_rsp_valid", rsp_valid, 0);
    check("release_busy", busy, 0);
    last_grant = w;
    ops_done++;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req_valid = '0; rsp_ready = '0; req_op = '0; req_a = '0; req_b = '0;
    last_grant = N - 1;
    ops_done = 0;
    repeat (2) @(posedge clk);
    #1;
    req_valid = {N{1'b1}};
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_c", rsp_c, 0);
    check("rst_rsp_ovf", rsp_ovf, 0);
    check("rst_alu", {alu_a, alu_b, alu_ctrl1, alu_ctrl0}, 0);
    check("rst_busy", busy, 0);
    req_valid = '0;
    rsp_ready = '0;
    @(posedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed ALU operations, one per requester
    load(0, 2'd0, 4'd9, 4'd8);
    send(4'b0001, 0);
    check("t1_grant", dut_grant, 0);
    check("t1_c", last_rsp_c, 4'h1);
    check("t1_ovf", last_rsp_ovf, 1);
    load(1, 2'd1, 4'd3, 4'd5);
    send(4'b0010, 0);
    check("t2_sub_c", last_rsp_c, 4'hE);
    check("t2_sub_ovf", last_rsp_ovf, 1);
    load(2, 2'd2, 4'hC, 4'hA);
    send(4'b0100, 0);
    check("t2_and_c", last_rsp_c, 4'h8);
    check("t2_and_ovf", last_rsp_ovf, 0);
    load(3, 2'd3, 4'd5, 4'd3);
    send(4'b1000, 0);
    check("t2_gt_c", last_rsp_c, 4'h1);
    check("t2_gt_ovf", last_rsp_ovf, 0);

    // All requesters valid: strict rotation, one acceptance per 3 cycles
    order.delete(); hs_t.delete();
    for (int i = 0; i < N; i++) load(i, 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));
    repeat (6) send(4'b1111, 0);
    for (int i = 0; i < 6; i++) check("rr_order", order[i], i % 4);
    for (int i = 1; i < 6; i++) check("throughput", 32'(hs_t[i] - hs_t[i-1]), 30);

    // Lone requester always wins regardless of last_grant
    repeat (3) begin
      load(1, 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));
      send(4'b0010, 0);
      check("lone_grant", dut_grant, 1);
    end

    // Back-pressure on requester 2
    load(2, 2'd0, 4'd7, 4'd6);
    send(4'b0100, 4);

    // Valid withdrawn before any clock edge: no transaction
    load(3, 2'd1, 4'd1, 4'd2);
    req_valid = 4'b1000;
    #1;
    check("drop_req_ready", req_ready, 4'b1000);
    req_valid = '0;
    @(posedge clk); #1;
    check("drop_busy", busy, 0);
    check("drop_alu_a", alu_a, 4'd7);

    // Reset during EXEC drops the in-flight op
    for (int i = 0; i < N; i++) load(i, 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    @(posedge clk); #1;
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_outs", {rsp_c, rsp_ovf, alu_a, alu_b, alu_ctrl1, alu_ctrl0, busy}, 0);
    rst_n = 1'b1;
    last_grant = N - 1;
    ops_done = 0;
    send(4'b1111, 0);
    check("post_rst_grant", dut_grant, 0);
    send(4'b0001, 0);
    send(4'b0001, 0);
`ifdef ALU_RR_SEQUENCER_STATS_EN
    check("stat_three", stat_ops, 3);
`endif

    // Randomized transactions against the reference model
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < N; i++) load(i, 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));
      send(N'($urandom_range(1, 15)), $urandom_range(0, 2));
    end
`ifdef ALU_RR_SEQUENCER_STATS_EN
    check("stat_count", stat_ops, 16'(ops_done));
    force dut.stat_ops = 16'hFFFF;
    @(posedge clk); #1;
    release dut.stat_ops;
    send(4'b0100, 0);
    check("stat_wrap", stat_ops, 16'h0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
